// File: rtl/wb_arbiter.sv
// wb_arbiter
// Write-back arbiter in front of the register file's single write port.
// In-order pipeline writes always win the port. Results from long-latency
// units arrive on a valid/ready channel, are written straight through when
// the port is free and nothing is queued, and are otherwise buffered in a
// small FIFO that drains in arrival order on free slots. A live pipeline
// write to register X kills queued entries destined for X (they are popped
// later without writing). A starvation counter raises stall_req_o when a
// non-empty FIFO has waited STARVE_MAX cycles without a pop.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   p_we_i/p_wa_i/p_wd_i/p_pc_i   pipeline write-back (enable, reg, data, pc)
//   s_valid_i/s_ready_o           secondary result handshake
//   s_wa_i/s_wd_i/s_pc_i          secondary result (reg, data, pc)
//   rf_we_o/rf_wa_o/rf_wd_o/rf_wpc_o  register-file write port (combinational)
//   stall_req_o       ask the pipeline for a bubble next cycle
//   pending_o         FIFO occupancy, killed entries included
module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       p_we_i,
  input  logic [4:0]                 p_wa_i,
  input  logic [31:0]                p_wd_i,
  input  logic [31:0]                p_pc_i,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic [4:0]                 s_wa_i,
  input  logic [31:0]                s_wd_i,
  input  logic [31:0]                s_pc_i,
  output logic                       rf_we_o,
  output logic [4:0]                 rf_wa_o,
  output logic [31:0]                rf_wd_o,
  output logic [31:0]                rf_wpc_o,
  output logic                       stall_req_o,
  output logic [$clog2(DEPTH):0]     pending_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(STARVE_MAX + 1);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [4:0]       wa_q [DEPTH];
  logic [31:0]      wd_q [DEPTH];
  logic [31:0]      pc_q [DEPTH];

  logic [PW-1:0]    count_s;
  logic [AW-1:0]    widx_s;
  logic [AW-1:0]    ridx_s;
  logic             empty_s;
  logic             full_s;
  logic             p_live_s;
  logic             free_s;
  logic             xfer_s;
  logic             bypass_s;
  logic             push_s;
  logic             pop_s;
  logic             head_vld_s;

  assign count_s  = wptr_q - rptr_q;
  assign widx_s   = wptr_q[AW-1:0];
  assign ridx_s   = rptr_q[AW-1:0];
  assign empty_s  = (count_s == {PW{1'b0}});
  assign full_s   = (count_s == PW'(DEPTH));

  assign p_live_s = p_we_i && (p_wa_i != 5'd0);
  // A free slot is any non-reset cycle without a live pipeline write.
  assign free_s   = !reset && !p_live_s;

  // s_ready depends only on occupancy and reset, never on the pipeline inputs.
  assign s_ready_o = !full_s && !reset;
  assign xfer_s    = s_valid_i && s_ready_o;

  assign pop_s      = free_s && !empty_s;
  assign bypass_s   = free_s && empty_s && s_valid_i && (s_wa_i != 5'd0);
  assign head_vld_s = vld_q[ridx_s];

  // Secondary results are older than a concurrent pipeline write, so an
  // incoming result to the same register is accepted but dropped.
  assign push_s = xfer_s && (s_wa_i != 5'd0) && !bypass_s &&
                  !(p_live_s && (s_wa_i == p_wa_i));

  assign stall_req_o = !reset && (cnt_q == CW'(STARVE_MAX));
  assign pending_o   = reset ? {PW{1'b0}} : count_s;

  // Register-file port mux: pipeline, then FIFO head, then bypass.
  always_comb begin
    rf_we_o  = 1'b0;
    rf_wa_o  = p_wa_i;
    rf_wd_o  = p_wd_i;
    rf_wpc_o = p_pc_i;
    if (reset) begin
      rf_we_o = 1'b0;
    end else if (p_live_s) begin
      rf_we_o = 1'b1;
    end else if (!empty_s) begin
      // A killed head is still popped, just without a write.
      rf_we_o  = head_vld_s;
      rf_wa_o  = wa_q[ridx_s];
      rf_wd_o  = wd_q[ridx_s];
      rf_wpc_o = pc_q[ridx_s];
    end else if (bypass_s) begin
      rf_we_o  = 1'b1;
      rf_wa_o  = s_wa_i;
      rf_wd_o  = s_wd_i;
      rf_wpc_o = s_pc_i;
    end else begin
      rf_we_o = 1'b0;
    end
  end

  // Next-state for pointers, valid bits and starvation counter.
  always_comb begin
    wptr_d = push_s ? (wptr_q + PW'(1)) : wptr_q;
    rptr_d = pop_s  ? (rptr_q + PW'(1)) : rptr_q;
    // Kill touches pre-existing entries only; the slot being pushed is set.
    for (int i = 0; i < DEPTH; i++) begin
      vld_d[i] = (push_s && (widx_s == AW'(i)))                ? 1'b1 :
                 (pop_s && (ridx_s == AW'(i)))                 ? 1'b0 :
                 (p_live_s && (wa_q[i] == p_wa_i))             ? 1'b0 :
                 vld_q[i];
    end
    if (empty_s || pop_s) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == CW'(STARVE_MAX)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= {PW{1'b0}};
      rptr_q <= {PW{1'b0}};
      vld_q  <= {DEPTH{1'b0}};
      cnt_q  <= {CW{1'b0}};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
    end
  end

  // FIFO payload storage; contents are qualified by the valid bits and pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      wa_q[widx_s] <= s_wa_i;
      wd_q[widx_s] <= s_wd_i;
      pc_q[widx_s] <= s_pc_i;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        p_we;
  logic [4:0]  p_wa;
  logic [31:0] p_wd;
  logic [31:0] p_pc;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_wa;
  logic [31:0] s_wd;
  logic [31:0] s_pc;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] rf_wpc;
  logic        stall_req;
  logic [2:0]  pending;

  int checks;
  int failures;

  wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .p_we_i(p_we), .p_wa_i(p_wa), .p_wd_i(p_wd), .p_pc_i(p_pc),
    .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_wa_i(s_wa), .s_wd_i(s_wd), .s_pc_i(s_pc),
    .rf_we_o(rf_we), .rf_wa_o(rf_wa), .rf_wd_o(rf_wd), .rf_wpc_o(rf_wpc),
    .stall_req_o(stall_req), .pending_o(pending)
  );

  // Free-running clock, posedge at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        pwe;
    logic [4:0]  pwa;
    logic [31:0] pwd;
    logic        sv;
    logic [4:0]  swa;
    logic [31:0] swd;
    logic        e_we;
    logic        e_src;   // 1: write comes from pipeline, 0: from secondary
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic [2:0]  e_pend;
    logic        e_stall;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] SPC_XOR = 32'h5A5A_5A5A;

  function automatic vec_t mk(input logic rst, input logic pwe, input logic [4:0] pwa,
                              input logic [31:0] pwd, input logic sv, input logic [4:0] swa,
                              input logic [31:0] swd, input logic ewe, input logic esrc,
                              input logic [4:0] ewa, input logic [31:0] ewd, input logic erdy,
                              input logic [2:0] epend, input logic estall);
    vec_t v;
    v.rst = rst; v.pwe = pwe; v.pwa = pwa; v.pwd = pwd;
    v.sv = sv; v.swa = swa; v.swd = swd;
    v.e_we = ewe; v.e_src = esrc; v.e_wa = ewa; v.e_wd = ewd;
    v.e_rdy = erdy; v.e_pend = epend; v.e_stall = estall;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  // PCs are derived from data so expected trace PCs follow from the source.
  task automatic drive(input logic rst, input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                       input logic sv, input logic [4:0] swa, input logic [31:0] swd);
    reset   = rst;
    p_we    = pwe;
    p_wa    = pwa;
    p_wd    = pwd;
    p_pc    = ~pwd;
    s_valid = sv;
    s_wa    = swa;
    s_wd    = swd;
    s_pc    = swd ^ SPC_XOR;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    //             rst  pwe  pwa    pwd           sv   swa     swd            we   src  wa     wd             rdy  pend  stall
    // reset, idle
    vecs.push_back(mk(1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0,  32'h0,         1'b0,1'b0,5'd0, 32'h0,         1'b0,3'd0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0,  32'h0,         1'b0,1'b0,5'd0, 32'h0,         1'b1,3'd0,1'b0));
    // bypass write
    vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd5,  32'hAAAA0001,  1'b1,1'b0,5'd5, 32'hAAAA0001,  1'b1,3'd0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0,  32'h0,         1'b0,1'b0,5'd0, 32'h0,         1'b1,3'd0,1'b0));
    // fill while pipeline holds the port
    vecs.push_back(mk(1'b0,1'b1,5'd3, 32'h300,     1'b1,5'd8,  32'hD8,        1'b1,1'b1,5'd3, 32'h300,       1'b1,3'd0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,5'd3, 32'h300,     1'b1,5'd9,  32'hD9,        1'b1,1'b1,5'd3, 32'h300,       1'b1,3'd1,1'b0));
    vecs.push_back(mk(1'b0,1'b1,5'd3, 32'h300,     1'b1,5'd10, 32'hDA,        1'b1,1'b1,5'd3, 32'h300,       1'b1,3'd2,1'b0));
    vecs.push_back(mk(1'b0,1'b1,5'd3, 32'h300,     1'b1,5'd11, 32'hDB,        1'b1,1'b1,5'd3, 32'h300,       1'b1,3'd3,1'b0));
    vecs.push_back(mk(1'b0,1'b1,5'd3, 32'h300,     1'b1,5'd12, 32'hDC,        1'b1,1'b1,5'd3, 32'h300,       1'b0,3'd4,1'b0));
    vecs.push_back(mk(1'b0,1'b1,5'd3, 32'h300,     1'b1,5'd12, 32'hDC,        1'b1,1'b1,5'd3, 32'h300,       1'b0,3'd4,1'b0));
    // drain in order, then the held result bypasses
    vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd12, 32'hDC,        1'b1,1'b0,5'd8, 32'hD8,        1'b0,3'd4,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd12, 32'hDC,        1'b1,1'b0,5'd9, 32'hD9,        1'b1,3'd3,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd12, 32'hDC,        1'b1,1'b0,5'd10,32'hDA,        1'b1,3'd2,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd12, 32'hDC,        1'b1,1'b0,5'd11,32'hDB,        1'b1,3'd1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd12, 32'hDC,        1'b1,1'b0,5'd12,32'hDC,        1'b1,3'd0,1'b0));
    // kill: queue wa=7, pipeline writes wa=7, killed head popped silently
    vecs.push_back(mk(1'b0,1'b1,5'd4, 32'h400,     1'b1,5'd7,  32'hD7,        1'b1,1'b1,5'd4, 32'h400,       1'b1,3'd0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,5'd7, 32'h1234,    1'b0,5'd0,  32'h0,         1'b1,1'b1,5'd7, 32'h1234,      1'b1,3'd1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0,  32'h0,         1'b0,1'b0,5'd0, 32'h0,         1'b1,3'd1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0,  32'h0,         1'b0,1'b0,5'd0, 32'h0,         1'b1,3'd0,1'b0));
    // zero register on both channels
    vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd0,  32'hEE,        1'b0,1'b0,5'd0, 32'h0,         1'b1,3'd0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0,  32'h0,         1'b0,1'b0,5'd0, 32'h0,         1'b1,3'd0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,5'd6, 32'h600,     1'b1,5'd14, 32'hDE,        1'b1,1'b1,5'd6, 32'h600,       1'b1,3'd0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,5'd6, 32'h600,     1'b1,5'd0,  32'hEF,        1'b1,1'b1,5'd6, 32'h600,       1'b1,3'd1,1'b0));
    vecs.push_back(mk(1'b0,1'b1,5'd0, 32'h999,     1'b0,5'd0,  32'h0,         1'b1,1'b0,5'd14,32'hDE,        1'b1,3'd1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0,  32'h0,         1'b0,1'b0,5'd0, 32'h0,         1'b1,3'd0,1'b0));
    // mid-operation reset with three entries queued
    vecs.push_back(mk(1'b0,1'b1,5'd1, 32'h100,     1'b1,5'd20, 32'hE0,        1'b1,1'b1,5'd1, 32'h100,       1'b1,3'd0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,5'd1, 32'h100,     1'b1,5'd21, 32'hE1,        1'b1,1'b1,5'd1, 32'h100,       1'b1,3'd1,1'b0));
    vecs.push_back(mk(1'b0,1'b1,5'd1, 32'h100,     1'b1,5'd22, 32'hE2,        1'b1,1'b1,5'd1, 32'h100,       1'b1,3'd2,1'b0));
    vecs.push_back(mk(1'b0,1'b1,5'd1, 32'h100,     1'b0,5'd0,  32'h0,         1'b1,1'b1,5'd1, 32'h100,       1'b1,3'd3,1'b0));
    vecs.push_back(mk(1'b1,1'b0,5'd0, 32'h0,       1'b0,5'd0,  32'h0,         1'b0,1'b0,5'd0, 32'h0,         1'b0,3'd0,1'b0));
    vecs.push_back(mk(1'b1,1'b0,5'd0, 32'h0,       1'b1,5'd9,  32'h99,        1'b0,1'b0,5'd0, 32'h0,         1'b0,3'd0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0,  32'h0,         1'b0,1'b0,5'd0, 32'h0,         1'b1,3'd0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0,  32'h0,         1'b0,1'b0,5'd0, 32'h0,         1'b1,3'd0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd9,  32'h99,        1'b1,1'b0,5'd9, 32'h99,        1'b1,3'd0,1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.rst, v.pwe, v.pwa, v.pwd, v.sv, v.swa, v.swd);
      @(negedge clk);
      chk("rf_we", i, {31'd0, rf_we}, {31'd0, v.e_we});
      chk("s_ready", i, {31'd0, s_ready}, {31'd0, v.e_rdy});
      chk("pending", i, {29'd0, pending}, {29'd0, v.e_pend});
      chk("stall_req", i, {31'd0, stall_req}, {31'd0, v.e_stall});
      if (v.e_we) begin
        chk("rf_wa", i, {27'd0, rf_wa}, {27'd0, v.e_wa});
        chk("rf_wd", i, rf_wd, v.e_wd);
        chk("rf_wpc", i, rf_wpc, v.e_src ? ~v.e_wd : (v.e_wd ^ SPC_XOR));
      end
      next_cycle();
    end

    // Starvation: push one entry while the pipeline keeps the port busy.
    drive(1'b0, 1'b1, 5'd2, 32'h200, 1'b1, 5'd17, 32'hF1);
    @(negedge clk);
    chk("starve_push_we", 100, {31'd0, rf_we}, 32'd1);
    chk("starve_push_pend", 100, {29'd0, pending}, 32'd0);
    next_cycle();
    drive(1'b0, 1'b1, 5'd2, 32'h200, 1'b0, 5'd0, 32'h0);
    // Cycle k follows the k-th edge after the push; stall from k=8 and holds.
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      chk("starve_stall", 101 + k, {31'd0, stall_req}, (k >= 8) ? 32'd1 : 32'd0);
      chk("starve_pend", 101 + k, {29'd0, pending}, 32'd1);
      next_cycle();
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("starve_pop_we", 120, {31'd0, rf_we}, 32'd1);
    chk("starve_pop_wa", 120, {27'd0, rf_wa}, 32'd17);
    chk("starve_pop_wd", 120, rf_wd, 32'hF1);
    chk("starve_pop_stall", 120, {31'd0, stall_req}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b1, 5'd2, 32'h200, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("starve_after_stall", 121, {31'd0, stall_req}, 32'd0);
    chk("starve_after_pend", 121, {29'd0, pending}, 32'd0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
